// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared MIPS encodings, ALU op codes, the decode/issue
//                control word (ctrl_t) and the issue FSM state type.
//                Optional feature macro used by the decoder: ILLEGAL_TRAP_EN.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

    // Primary opcodes. HALT lives at 6'h3E so that 6'h3F stays an unknown opcode.
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B,
        OP_LL    = 6'h30,
        OP_SC    = 6'h38,
        OP_HALT  = 6'h3E
    } opcode_t;

    // R-type function codes
    typedef enum logic [5:0] {
        FN_SLL   = 6'h00,
        FN_SRL   = 6'h02,
        FN_JR    = 6'h08,
        FN_MULTU = 6'h19,
        FN_DIVU  = 6'h1B,
        FN_ADD   = 6'h20,
        FN_ADDU  = 6'h21,
        FN_SUB   = 6'h22,
        FN_SUBU  = 6'h23,
        FN_AND   = 6'h24,
        FN_OR    = 6'h25,
        FN_XOR   = 6'h26,
        FN_NOR   = 6'h27,
        FN_SLT   = 6'h2A,
        FN_SLTU  = 6'h2B
    } funct_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    // Control word handed across the ID/EX boundary
    typedef struct packed {
        logic        RegDst;
        logic        RegWr;
        logic        ImmToReg;
        logic        ExtOp;
        logic        ShamToAlu;
        logic        ImmToAlu;
        logic        DataRead;
        logic        DataWrite;
        logic        BrEq;
        logic        BrNeq;
        logic        Jump;
        logic        Jr;
        logic        Jal;
        logic        Halt;
        logic        MulStart;
        logic        DivStart;
        logic        Illegal;
        aluop_t      aluop;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm16;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MWAIT     = 2'd1,
        HALT_PEND = 2'd2,
        HALTED    = 2'd3
    } ctrl_state_t;

    // Initial down-counter value for a multi-cycle op of latency lat (1..15).
    // Latency 1 maps to 0, meaning no wait state at all.
    function automatic logic [3:0] lat_to_cnt(input int lat);
        if (lat <= 1)
            return 4'd0;
        else if (lat >= 15)
            return 4'd14;
        else
            return 4'(lat - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_comb.sv
`default_nettype none
// ============================================================================
//  Module      : decode_comb
//  Description : Purely combinational MIPS instruction -> ctrl_t decoder.
//                ILLEGAL_TRAP_EN: when defined, unknown opcodes / R-type
//                functs raise Illegal and Halt; otherwise they decode as NOP.
//  Revision    : 1.0  initial release
// ============================================================================
module decode_comb
    import cpu_types_pkg::*;
(
    input  logic [31:0]       i_instr,
    output logic [CTRL_W-1:0] o_ctrl
);

`ifdef ILLEGAL_TRAP_EN
    localparam bit c_trap_en = 1'b1;
`else
    localparam bit c_trap_en = 1'b0;
`endif

    opcode_t w_op;
    funct_t  w_fn;
    ctrl_t   w_c;
    logic    w_illegal;

    assign w_op = opcode_t'(i_instr[31:26]);
    assign w_fn = funct_t'(i_instr[5:0]);

    // Decode opcode/funct into control bits; unknown encodings leave all bits low
    always_comb begin
        w_c           = '0;
        w_c.aluop     = ALU_ADD;
        w_c.rs        = i_instr[25:21];
        w_c.rt        = i_instr[20:16];
        w_c.rd        = i_instr[15:11];
        w_c.shamt     = i_instr[10:6];
        w_c.imm16     = i_instr[15:0];
        w_illegal     = 1'b0;

        case (w_op)
            OP_RTYPE: begin
                w_c.RegDst = 1'b1;
                w_c.RegWr  = 1'b1;
                case (w_fn)
                    FN_SLL:  begin w_c.ShamToAlu = 1'b1; w_c.aluop = ALU_SLL; end
                    FN_SRL:  begin w_c.ShamToAlu = 1'b1; w_c.aluop = ALU_SRL; end
                    FN_JR:   begin w_c.RegDst = 1'b0; w_c.RegWr = 1'b0; w_c.Jr = 1'b1; end
                    // HI/LO results only: no GPR write
                    FN_MULTU: begin w_c.RegWr = 1'b0; w_c.MulStart = 1'b1; end
                    FN_DIVU:  begin w_c.RegWr = 1'b0; w_c.DivStart = 1'b1; end
                    FN_ADD, FN_ADDU: w_c.aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: w_c.aluop = ALU_SUB;
                    FN_AND:  w_c.aluop = ALU_AND;
                    FN_OR:   w_c.aluop = ALU_OR;
                    FN_XOR:  w_c.aluop = ALU_XOR;
                    FN_NOR:  w_c.aluop = ALU_NOR;
                    FN_SLT:  w_c.aluop = ALU_SLT;
                    FN_SLTU: w_c.aluop = ALU_SLTU;
                    default: begin
                        w_c.RegDst = 1'b0;
                        w_c.RegWr  = 1'b0;
                        w_illegal  = 1'b1;
                    end
                endcase
            end
            OP_J:    w_c.Jump = 1'b1;
            OP_JAL:  begin w_c.Jump = 1'b1; w_c.Jal = 1'b1; w_c.RegWr = 1'b1; end
            OP_BEQ:  w_c.BrEq  = 1'b1;
            OP_BNE:  w_c.BrNeq = 1'b1;
            OP_ADDIU: begin
                w_c.RegWr = 1'b1; w_c.ExtOp = 1'b1; w_c.ImmToAlu = 1'b1; w_c.aluop = ALU_ADD;
            end
            OP_SLTI: begin
                w_c.RegWr = 1'b1; w_c.ExtOp = 1'b1; w_c.ImmToAlu = 1'b1; w_c.aluop = ALU_SLT;
            end
            OP_SLTIU: begin
                w_c.RegWr = 1'b1; w_c.ExtOp = 1'b1; w_c.ImmToAlu = 1'b1; w_c.aluop = ALU_SLTU;
            end
            OP_ANDI: begin w_c.RegWr = 1'b1; w_c.ImmToAlu = 1'b1; w_c.aluop = ALU_AND; end
            OP_ORI:  begin w_c.RegWr = 1'b1; w_c.ImmToAlu = 1'b1; w_c.aluop = ALU_OR;  end
            OP_XORI: begin w_c.RegWr = 1'b1; w_c.ImmToAlu = 1'b1; w_c.aluop = ALU_XOR; end
            OP_LUI:  begin w_c.RegWr = 1'b1; w_c.ImmToAlu = 1'b1; w_c.ImmToReg = 1'b1; end
            OP_LW, OP_LL: begin
                w_c.RegWr = 1'b1; w_c.ExtOp = 1'b1; w_c.ImmToAlu = 1'b1; w_c.DataRead = 1'b1;
            end
            OP_SW: begin
                w_c.ExtOp = 1'b1; w_c.ImmToAlu = 1'b1; w_c.DataWrite = 1'b1;
            end
            // SC writes its success flag back to rt
            OP_SC: begin
                w_c.RegWr = 1'b1; w_c.ExtOp = 1'b1; w_c.ImmToAlu = 1'b1; w_c.DataWrite = 1'b1;
            end
            OP_HALT: w_c.Halt = 1'b1;
            default: w_illegal = 1'b1;
        endcase

        if (c_trap_en && w_illegal) begin
            w_c.Illegal = 1'b1;
            w_c.Halt    = 1'b1;
        end
    end

    assign o_ctrl = w_c;

endmodule
`default_nettype wire

// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_control_unit
//  Description : Decode/issue stage. Accepts instructions over valid/ready,
//                registers the decoded control word toward EX, stalls issue
//                for MULTU/DIVU latency, handles flush and a sticky HALT.
//                Optional macro (in decode_comb): ILLEGAL_TRAP_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module pipelined_control_unit
    import cpu_types_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
)(
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    output logic              in_ready,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              busy,
    output logic              halted
);

    localparam logic [3:0] c_mul_cnt = lat_to_cnt(MUL_LAT);
    localparam logic [3:0] c_div_cnt = lat_to_cnt(DIV_LAT);

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic              r_out_valid;
    ctrl_t             r_out_ctrl;
    logic [CTRL_W-1:0] w_dec_bits;
    ctrl_t             w_dec;
    logic              w_accept;

    decode_comb u_decode (
        .i_instr (in_instr),
        .o_ctrl  (w_dec_bits)
    );

    assign w_dec = ctrl_t'(w_dec_bits);

    // Ready only in RUN, never while flushing or in reset, and only if the
    // output slot is empty or draining this cycle
    assign in_ready  = nRST && (r_state == RUN) && !flush && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign out_ctrl  = r_out_ctrl;
    assign busy      = (r_state == MWAIT);
    assign halted    = (r_state == HALTED);

    // State and latency counter registers
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; flush wins over everything except a completed halt
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush) begin
            w_cnt_nxt = 4'd0;
            if (r_state != HALTED)
                w_state_nxt = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_accept) begin
                        if (w_dec.Halt) begin
                            w_state_nxt = HALT_PEND;
                        end else if (w_dec.MulStart && (c_mul_cnt != 4'd0)) begin
                            w_state_nxt = MWAIT;
                            w_cnt_nxt   = c_mul_cnt;
                        end else if (w_dec.DivStart && (c_div_cnt != 4'd0)) begin
                            w_state_nxt = MWAIT;
                            w_cnt_nxt   = c_div_cnt;
                        end
                    end
                end
                // Leave on the edge where the counter reaches zero
                MWAIT: begin
                    if (r_cnt <= 4'd1) begin
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                HALT_PEND: begin
                    if (r_out_valid && out_ready)
                        w_state_nxt = HALTED;
                end
                HALTED:  w_state_nxt = HALTED;
                default: w_state_nxt = RUN;
            endcase
        end
    end

    // ID/EX output register: load on accept, drop valid once EX takes it
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_out_valid <= 1'b0;
            r_out_ctrl  <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_ctrl  <= w_dec;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_control_unit
//  Description : Directed, table-driven bench for pipelined_control_unit.
//                Honours ILLEGAL_TRAP_EN for the unknown-opcode sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipelined_control_unit;
    import cpu_types_pkg::*;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              in_valid;
    logic [31:0]       in_instr;
    logic              in_ready;
    logic              flush;
    logic              out_ready;
    logic              out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic              busy;
    logic              halted;

    ctrl_t c;
    assign c = ctrl_t'(out_ctrl);

    int n_vec = 0;
    int n_err = 0;

    // Flag bit positions, MSB first: RegDst .. Illegal
    localparam logic [16:0] c_regdst = 17'h10000;
    localparam logic [16:0] c_regwr  = 17'h08000;
    localparam logic [16:0] c_imm2rg = 17'h04000;
    localparam logic [16:0] c_extop  = 17'h02000;
    localparam logic [16:0] c_sham   = 17'h01000;
    localparam logic [16:0] c_immalu = 17'h00800;
    localparam logic [16:0] c_dread  = 17'h00400;
    localparam logic [16:0] c_dwrite = 17'h00200;
    localparam logic [16:0] c_breq   = 17'h00100;
    localparam logic [16:0] c_brneq  = 17'h00080;
    localparam logic [16:0] c_jump   = 17'h00040;
    localparam logic [16:0] c_jr     = 17'h00020;
    localparam logic [16:0] c_jal    = 17'h00010;
    localparam logic [16:0] c_r      = c_regdst | c_regwr;
    localparam logic [31:0] c_halt_i = 32'hF800_0000;

    typedef struct {
        logic [31:0] instr;
        logic [16:0] flags;
        aluop_t      aluop;
        string       name;
    } vec_t;

    localparam int N_VEC = 27;
    vec_t tbl [N_VEC];

    pipelined_control_unit #(.MUL_LAT(4), .DIV_LAT(8)) u_dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_ctrl  (out_ctrl),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [16:0] flags_of(input ctrl_t x);
        return {x.RegDst, x.RegWr, x.ImmToReg, x.ExtOp, x.ShamToAlu, x.ImmToAlu,
                x.DataRead, x.DataWrite, x.BrEq, x.BrNeq, x.Jump, x.Jr, x.Jal,
                x.Halt, x.MulStart, x.DivStart, x.Illegal};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{rtype(1, 2, 3, 0, 6'h21), c_r, ALU_ADD, "addu"};
        tbl[1]  = '{rtype(4, 5, 6, 0, 6'h22), c_r, ALU_SUB, "sub"};
        tbl[2]  = '{rtype(4, 5, 6, 0, 6'h24), c_r, ALU_AND, "and"};
        tbl[3]  = '{rtype(4, 5, 6, 0, 6'h25), c_r, ALU_OR,  "or"};
        tbl[4]  = '{rtype(4, 5, 6, 0, 6'h26), c_r, ALU_XOR, "xor"};
        tbl[5]  = '{rtype(4, 5, 6, 0, 6'h27), c_r, ALU_NOR, "nor"};
        tbl[6]  = '{rtype(4, 5, 6, 0, 6'h2A), c_r, ALU_SLT, "slt"};
        tbl[7]  = '{rtype(4, 5, 6, 0, 6'h2B), c_r, ALU_SLTU, "sltu"};
        tbl[8]  = '{rtype(0, 2, 7, 5, 6'h00), c_r | c_sham, ALU_SLL, "sll"};
        tbl[9]  = '{rtype(0, 2, 7, 5, 6'h02), c_r | c_sham, ALU_SRL, "srl"};
        tbl[10] = '{rtype(31, 0, 0, 0, 6'h08), c_jr, ALU_ADD, "jr"};
        tbl[11] = '{itype(6'h09, 1, 2, 16'hFFFC), c_regwr | c_extop | c_immalu, ALU_ADD, "addiu"};
        tbl[12] = '{itype(6'h0A, 1, 2, 16'h0005), c_regwr | c_extop | c_immalu, ALU_SLT, "slti"};
        tbl[13] = '{itype(6'h0B, 1, 2, 16'h0005), c_regwr | c_extop | c_immalu, ALU_SLTU, "sltiu"};
        tbl[14] = '{itype(6'h0C, 1, 2, 16'h0F0F), c_regwr | c_immalu, ALU_AND, "andi"};
        tbl[15] = '{itype(6'h0E, 1, 2, 16'h0F0F), c_regwr | c_immalu, ALU_XOR, "xori"};
        tbl[16] = '{itype(6'h0F, 0, 2, 16'hABCD), c_regwr | c_imm2rg | c_immalu, ALU_ADD, "lui"};
        tbl[17] = '{itype(6'h23, 1, 2, 16'h0008), c_regwr | c_extop | c_immalu | c_dread, ALU_ADD, "lw"};
        tbl[18] = '{itype(6'h2B, 1, 2, 16'h0008), c_extop | c_immalu | c_dwrite, ALU_ADD, "sw"};
        tbl[19] = '{itype(6'h30, 1, 2, 16'h0008), c_regwr | c_extop | c_immalu | c_dread, ALU_ADD, "ll"};
        tbl[20] = '{itype(6'h38, 1, 2, 16'h0008), c_regwr | c_extop | c_immalu | c_dwrite, ALU_ADD, "sc"};
        tbl[21] = '{itype(6'h04, 1, 2, 16'h0003), c_breq, ALU_ADD, "beq"};
        tbl[22] = '{itype(6'h05, 1, 2, 16'h0003), c_brneq, ALU_ADD, "bne"};
        tbl[23] = '{itype(6'h02, 0, 0, 16'h0040), c_jump, ALU_ADD, "j"};
        tbl[24] = '{itype(6'h03, 0, 0, 16'h0040), c_regwr | c_jump | c_jal, ALU_ADD, "jal"};
        tbl[25] = '{rtype(7, 8, 9, 0, 6'h20), c_r, ALU_ADD, "add"};
        tbl[26] = '{rtype(7, 8, 9, 0, 6'h23), c_r, ALU_SUB, "subu"};

        nRST = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;

        // Reset state
        @(negedge CLK);
        chk("rst_in_ready", in_ready, 0);
        @(negedge CLK);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        nRST = 1'b1;
        #1 chk("post_rst_in_ready", in_ready, 1);

        // Decode table, issued back to back with out_ready high
        for (int i = 0; i < N_VEC; i++) begin
            in_instr = tbl[i].instr;
            in_valid = 1'b1;
            @(negedge CLK);
            chk({tbl[i].name, "_valid"}, out_valid, 1);
            chk({tbl[i].name, "_flags"}, flags_of(c), tbl[i].flags);
            chk({tbl[i].name, "_aluop"}, c.aluop, tbl[i].aluop);
        end
        in_valid = 1'b0;
        @(negedge CLK);
        chk("tbl_drain", out_valid, 0);

        // ADDU then ORI back to back
        in_instr = rtype(1, 2, 3, 0, 6'h21); in_valid = 1'b1;
        @(negedge CLK);
        chk("a1_valid", out_valid, 1);
        chk("a1_aluop", c.aluop, ALU_ADD);
        chk("a1_regdst", c.RegDst, 1);
        chk("a1_rd", c.rd, 3);
        in_instr = itype(6'h0D, 3, 4, 16'h00FF);
        @(negedge CLK);
        in_valid = 1'b0;
        chk("a2_valid", out_valid, 1);
        chk("a2_aluop", c.aluop, ALU_OR);
        chk("a2_regdst", c.RegDst, 0);
        chk("a2_imm16", c.imm16, 16'h00FF);
        chk("a2_rt", c.rt, 4);

        // MULTU: 3 blocked cycles, ADDIU accepted on the 4th
        in_instr = rtype(5, 6, 0, 0, 6'h19); in_valid = 1'b1;
        @(negedge CLK);
        chk("b_mulstart", c.MulStart, 1);
        chk("b_regwr", c.RegWr, 0);
        in_instr = itype(6'h09, 1, 8, 16'h0010);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("b_busy", busy, 1);
            chk("b_in_ready", in_ready, 0);
            @(negedge CLK);
        end
        #1;
        chk("b_busy_end", busy, 0);
        chk("b_ready_end", in_ready, 1);
        chk("b_no_issue", out_valid, 0);
        @(negedge CLK);
        in_valid = 1'b0;
        chk("b_addiu_valid", out_valid, 1);
        chk("b_addiu_flags", flags_of(c), c_regwr | c_extop | c_immalu);
        chk("b_addiu_imm", c.imm16, 16'h0010);

        // LW held by out_ready=0 for 5 cycles, then SW follows with no bubble
        in_instr = itype(6'h23, 2, 9, 16'h0040); in_valid = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        in_instr = itype(6'h2B, 2, 10, 16'h0044);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("c_hold_valid", out_valid, 1);
            chk("c_hold_flags", flags_of(c), c_regwr | c_extop | c_immalu | c_dread);
            chk("c_hold_imm", c.imm16, 16'h0040);
            chk("c_hold_in_ready", in_ready, 0);
            @(negedge CLK);
        end
        out_ready = 1'b1;
        #1 chk("c_release_ready", in_ready, 1);
        @(negedge CLK);
        in_valid = 1'b0;
        chk("c_sw_valid", out_valid, 1);
        chk("c_sw_dwrite", c.DataWrite, 1);
        chk("c_sw_imm", c.imm16, 16'h0044);
        @(negedge CLK);
        chk("c_drain", out_valid, 0);

        // DIVU flushed on the 3rd MWAIT cycle
        out_ready = 1'b0;
        in_instr = rtype(3, 4, 0, 0, 6'h1B); in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        chk("d_divstart", c.DivStart, 1);
        chk("d_busy1", busy, 1);
        @(negedge CLK);
        chk("d_busy2", busy, 1);
        @(negedge CLK);
        chk("d_busy3", busy, 1);
        flush = 1'b1;
        #1 chk("d_flush_ready", in_ready, 0);
        @(negedge CLK);
        flush = 1'b0;
        #1;
        chk("d_valid_after", out_valid, 0);
        chk("d_busy_after", busy, 0);
        chk("d_ready_after", in_ready, 1);

        // HALT killed by flush while pending
        in_instr = c_halt_i; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        chk("e0_halt_bit", c.Halt, 1);
        chk("e0_ready", in_ready, 0);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        #1;
        chk("e0_halted", halted, 0);
        chk("e0_ready_after", in_ready, 1);

        // HALT held two cycles, then consumed: sticky until reset
        in_instr = c_halt_i; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        chk("e_valid", out_valid, 1);
        chk("e_flags", flags_of(c), 17'h00008);
        chk("e_halted1", halted, 0);
        chk("e_ready1", in_ready, 0);
        @(negedge CLK);
        chk("e_halted2", halted, 0);
        out_ready = 1'b1;
        @(negedge CLK);
        chk("e_halted3", halted, 1);
        chk("e_valid3", out_valid, 0);
        in_instr = rtype(1, 2, 3, 0, 6'h21); in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("e_ignore_valid", out_valid, 0);
            chk("e_ignore_ready", in_ready, 0);
        end
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        chk("e_flush_halted", halted, 1);
        nRST = 1'b0; in_valid = 1'b0;
        #1 chk("e_rst_ready", in_ready, 0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk("e_rst_halted", halted, 0);
        chk("e_rst_valid", out_valid, 0);
        chk("e_rst_ready2", in_ready, 1);

        // Unknown opcode 6'h3F
        in_instr = itype(6'h3F, 1, 2, 16'h1234); in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        chk("f_valid", out_valid, 1);
        chk("f_regwr", c.RegWr, 0);
        chk("f_dwrite", c.DataWrite, 0);
`ifdef ILLEGAL_TRAP_EN
        chk("f_illegal", c.Illegal, 1);
        chk("f_halt", c.Halt, 1);
        @(negedge CLK);
        chk("f_halted", halted, 1);
`else
        chk("f_flags", flags_of(c), 0);
        chk("f_ready", in_ready, 1);
        in_instr = rtype(1, 2, 3, 0, 6'h3F); in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        chk("f_rfn_flags", flags_of(c), 0);
        chk("f_halted", halted, 0);
        chk("f_busy", busy, 0);
        chk("f_ready2", in_ready, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Decode/issue stage for the pipelined MIPS core. Takes fetched 32-bit instructions over a valid/ready handshake and decodes opcode/funct into a registered control word plus register fields.
- Drives the ID/EX boundary with its own valid/ready handshake.
- Adds multi-cycle MULTU/DIVU issue stalls, flush and sticky halt on top of single-cycle decode.

Parameters:
- MUL_LAT, 4, MULTU execute latency in cycles (1..15); younger issue is blocked for this many cycles.
- DIV_LAT, 8, DIVU execute latency in cycles (1..15).

Ports:
- CLK  in  1  core clock.
- nRST  in  1  reset, synchronous, active-low.
- in_valid  in  1  fetch has an instruction.
- in_instr  in  32  instruction word.
- in_ready  out  1  stage accepts in_instr this cycle.
- flush  in  1  kill the stage contents (branch/jump redirect).
- out_ready  in  1  EX accepts the control word.
- out_valid  out  1  control word valid.
- out_ctrl  out  CTRL_W  packed ctrl_t.
  - Fields: RegDst, RegWr, ImmToReg, ExtOp, ShamToAlu, ImmToAlu, DataRead, DataWrite, BrEq, BrNeq, Jump, Jr, Jal, Halt, MulStart, DivStart, Illegal, aluop, rs, rt, rd, shamt, imm16.
- busy  out  1  multi-cycle op outstanding.
- halted  out  1  HALT consumed by EX; sticky.

Behaviour:
- Reset (nRST low at a CLK edge): state=RUN, out_valid=0, out_ctrl='0, cnt=0, busy=0, halted=0, in_ready=0 during the reset cycle.
- Decode rules:
  - RegDst=RTYPE&&funct!=JR.
  - RegWr is low for JR, BEQ, BNE, SW, J and HALT; also low for MULTU/DIVU (HI/LO only).
  - ExtOp is high for ADDIU, LW, SW, SLTI, SLTIU, LL, SC.
  - ShamToAlu=RTYPE&&(SLL||SRL).
  - ImmToAlu is high for any non-RTYPE except BEQ, BNE, J, JAL, HALT.
  - DataRead=LW||LL; DataWrite=SW||SC; Jump=J||JAL; Jal=JAL; Jr=RTYPE&&JR; ImmToReg=LUI.
  - aluop maps ADD/ADDU/ADDIU→ADD, SUB/SUBU→SUB, AND/ANDI, OR/ORI, XOR/XORI, NOR, SLT/SLTI, SLTU/SLTIU, SLL, SRL. Default is ALU_ADD.
  - MulStart=RTYPE&&MULTU; DivStart=RTYPE&&DIVU.
- Latency: an instruction accepted at edge N appears on out_ctrl/out_valid after edge N; decode-to-output is 1 cycle.
- Handshake:
  - accept = in_valid&&in_ready.
  - in_ready = (state==RUN)&&!flush&&(!out_valid||out_ready).
  - out register loads on accept; it clears out_valid when out_ready&&out_valid&&!accept.
  - out_ctrl holds stable while out_valid&&!out_ready.
- FSM states RUN, MWAIT, HALT_PEND, HALTED:
  - RUN→MWAIT on accept of MULTU (cnt=MUL_LAT-1) or DIVU (cnt=DIV_LAT-1). If the latency is 1, stay in RUN.
  - MWAIT: busy=1, in_ready=0, cnt decrements each cycle; →RUN when cnt==0. Down-counter width is 4 bits.
  - RUN→HALT_PEND on accept of HALT; in_ready=0.
  - HALT_PEND→HALTED when the HALT word handshakes out (out_valid&&out_ready).
  - HALTED: in_ready=0, halted=1 until reset.
- flush:
  - Takes priority over accept in the same cycle: out_valid←0, cnt←0.
  - MWAIT→RUN and HALT_PEND→RUN.
  - HALTED is unaffected.
- Simultaneous out_ready handshake and new accept: the new word replaces the old one; out_valid stays 1.
- Reset mid-MWAIT or mid-HALT_PEND: returns to the reset values above on that edge.

Optional Feature:
- ILLEGAL_TRAP_EN defined:
  - An unknown opcode, or an RTYPE funct outside the decoded set, sets Illegal=1 and Halt=1, and the FSM enters HALT_PEND.
- Undefined:
  - The same instruction decodes as a NOP: all write/mem/branch bits 0, Illegal=0.
  - The FSM stays in RUN.

Decomposition:
- cpu_types_pkg gains:
  - funct_t values MULTU=6'h19 and DIVU=6'h1B.
  - ctrl_t packed struct and CTRL_W.
  - typedef ctrl_state_t {RUN, MWAIT, HALT_PEND, HALTED}.
- One natural sub-module: decode_comb, a purely combinational instr→ctrl_t decoder.
- The pipelined_control_unit top holds the FSM, counter and output register.

Test Plan:
- Back-to-back ADDU $3,$1,$2 then ORI $4,$3,0x00FF with out_ready=1 → two consecutive out_valid cycles; aluop ADD then OR; RegDst 1 then 0; imm16=0x00FF.
- MULTU with MUL_LAT=4 → MulStart=1 next cycle; busy=1 and in_ready=0 for 3 cycles; next ADDIU accepted on the 4th cycle.
- out_ready held 0 for 5 cycles with LW pending → out_ctrl stable, DataRead=1, in_ready=0; on release the next word follows with no bubble.
- DIVU (DIV_LAT=8) with flush on cycle 3 of MWAIT → out_valid=0, busy=0, in_ready=1 the next cycle.
- HALT accepted, out_ready=0 two cycles then 1 → halted=1 one cycle after the handshake; later in_valid is ignored; nRST low for one edge clears halted.
- Opcode 6'h3F: with ILLEGAL_TRAP_EN → Illegal=1, Halt=1, halted after the handshake; without it → RegWr=0, DataWrite=0, state stays RUN.
